// File: rtl/b1_mux_3_1_rr.sv
// b1_mux_3_1_rr: three-input round-robin stream merger with a registered output.
// Each output beat carries its source index on out_sel (2'b11 = no beat).
// Optional build macro B1_MUX_GRANT_CNT_EN adds saturating per-channel grant
// counters grant_cnt0..grant_cnt2 (CNT_W bits each).
module b1_mux_3_1_rr #(
  parameter int DATA_W = 1,
  parameter int CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            in_valid,
  input  logic [3*DATA_W-1:0]   in_data,
  output logic [2:0]            in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [1:0]            out_sel
`ifdef B1_MUX_GRANT_CNT_EN
  ,
  output logic [CNT_W-1:0]      grant_cnt0,
  output logic [CNT_W-1:0]      grant_cnt1,
  output logic [CNT_W-1:0]      grant_cnt2
`endif
);

  localparam logic [1:0] SEL_NONE = 2'b11;

  logic [1:0]        ptr_reg;
  logic              out_valid_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic [1:0]        out_sel_reg;

  logic              load;
  logic              accept;
  logic [2:0]        grant;
  logic [1:0]        grant_idx;
  logic              grant_any;
  logic [1:0]        ptr_next;
  logic [DATA_W-1:0] grant_data;
  logic [DATA_W-1:0] masked_data [3];

  // Channel reached after stepping k places from p, modulo 3 (p is always 0..2).
  function automatic logic [1:0] rr_idx(input logic [1:0] p, input int k);
    logic [2:0] s;
    s = {1'b0, p} + 3'(k);
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  // The output register can accept a beat when empty or being drained; never during reset.
  assign load   = !out_valid_reg || out_ready;
  assign accept = load && !rst;

  // Round-robin scan starting at ptr; first valid channel wins.
  always_comb begin
    logic [1:0] idx;
    logic       found;
    grant     = 3'b000;
    grant_idx = SEL_NONE;
    found     = 1'b0;
    idx       = ptr_reg;
    for (int k = 0; k < 3; k++) begin
      idx = rr_idx(ptr_reg, k);
      if (!found && in_valid[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        found      = 1'b1;
      end
    end
  end

  assign in_ready  = accept ? grant : 3'b000;
  assign grant_any = |in_ready;
  assign ptr_next  = (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;

  // One-hot AND-OR data mux: only the granted channel contributes.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_mask
      assign masked_data[gi] = in_data[gi*DATA_W +: DATA_W] & {DATA_W{grant[gi]}};
    end
  endgenerate
  assign grant_data = masked_data[0] | masked_data[1] | masked_data[2];

  // Output beat register and priority pointer; pointer moves only on a transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sel_reg   <= SEL_NONE;
      ptr_reg       <= 2'd0;
    end else if (load) begin
      if (grant_any) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= grant_data;
        out_sel_reg   <= grant_idx;
        ptr_reg       <= ptr_next;
      end else begin
        out_valid_reg <= 1'b0;
        out_data_reg  <= '0;
        out_sel_reg   <= SEL_NONE;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_sel   = out_sel_reg;

`ifdef B1_MUX_GRANT_CNT_EN
  logic [CNT_W-1:0] cnt_reg [3];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      // Count transfers from this channel, saturating at all-ones.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg[gi] <= '0;
        end else if (in_valid[gi] && in_ready[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
          cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
        end
      end
    end
  endgenerate

  assign grant_cnt0 = cnt_reg[0];
  assign grant_cnt1 = cnt_reg[1];
  assign grant_cnt2 = cnt_reg[2];
`endif

endmodule

// File: tb/tb_b1_mux_3_1_rr.sv
// Directed testbench for b1_mux_3_1_rr (DATA_W=4, CNT_W=2).
// Channel data: ch0=4'hA, ch1=4'h1, ch2=4'hC.
module tb_b1_mux_3_1_rr;

  localparam int DATA_W = 4;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        in_valid;
  logic [3*DATA_W-1:0] in_data;
  logic [2:0]        in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_sel;
`ifdef B1_MUX_GRANT_CNT_EN
  logic [CNT_W-1:0]  grant_cnt0, grant_cnt1, grant_cnt2;
`endif

  int asserts  = 0;
  int failures = 0;

  b1_mux_3_1_rr #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sel(out_sel)
`ifdef B1_MUX_GRANT_CNT_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .grant_cnt2(grant_cnt2)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 3'b000; out_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 3'b111; out_ready = 1'b1;
    #1;
    asserts++;
    if (in_ready !== 3'b000) begin failures++; $display("FAIL rst_in_ready: got %b want 000", in_ready); end
    tick(); tick();
    rst = 1'b0; in_valid = 3'b000;
    #1;
    asserts++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    asserts++;
    if (out_sel !== 2'b11) begin failures++; $display("FAIL reset_out_sel: got %b want 11", out_sel); end
    asserts++;
    if (out_data !== 4'h0) begin failures++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    asserts++;
    if (in_ready !== 3'b000) begin failures++; $display("FAIL idle_in_ready: got %b want 000", in_ready); end
    tick();
    asserts++;
    if (out_valid !== 1'b0 || out_sel !== 2'b11) begin
      failures++; $display("FAIL idle_out: got valid=%b sel=%b want 0/11", out_valid, out_sel);
    end
    $display("test_reset done");
  endtask

  task automatic test_single();
    in_valid = 3'b010; out_ready = 1'b1;
    #1;
    asserts++;
    if (in_ready !== 3'b010) begin failures++; $display("FAIL single_in_ready: got %b want 010", in_ready); end
    tick();
    asserts++;
    if (out_valid !== 1'b1 || out_data !== 4'h1 || out_sel !== 2'b01) begin
      failures++; $display("FAIL single_out: got v=%b d=%h s=%b want 1/1/01", out_valid, out_data, out_sel);
    end
    // ptr now 2: with ch0 and ch1 valid, scan 2,0,1 picks ch0
    in_valid = 3'b011;
    #1;
    asserts++;
    if (in_ready !== 3'b001) begin failures++; $display("FAIL ptr_after_ch1: got %b want 001", in_ready); end
    tick();
    asserts++;
    if (out_sel !== 2'b00 || out_data !== 4'hA) begin
      failures++; $display("FAIL ptr_after_ch1_out: got s=%b d=%h want 00/A", out_sel, out_data);
    end
    // idle cycle: output empties, ptr (now 1) unchanged
    in_valid = 3'b000;
    tick();
    asserts++;
    if (out_valid !== 1'b0 || out_sel !== 2'b11 || out_data !== 4'h0) begin
      failures++; $display("FAIL idle_after_beat: got v=%b s=%b d=%h want 0/11/0", out_valid, out_sel, out_data);
    end
    in_valid = 3'b101;
    #1;
    asserts++;
    if (in_ready !== 3'b100) begin failures++; $display("FAIL ptr_hold_idle: got %b want 100", in_ready); end
    in_valid = 3'b000;
    tick();
    $display("test_single done");
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_rdy;
    logic [1:0] exp_sel;
    logic [3:0] exp_data;
    do_reset();
    in_valid = 3'b111; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_rdy  = 3'b001 << (i % 3);
      exp_sel  = 2'(i % 3);
      exp_data = (i % 3 == 0) ? 4'hA : (i % 3 == 1) ? 4'h1 : 4'hC;
      #1;
      asserts++;
      if (in_ready !== exp_rdy) begin failures++; $display("FAIL rr_in_ready[%0d]: got %b want %b", i, in_ready, exp_rdy); end
      tick();
      asserts++;
      if (out_valid !== 1'b1 || out_sel !== exp_sel || out_data !== exp_data) begin
        failures++; $display("FAIL rr_out[%0d]: got v=%b s=%b d=%h want 1/%b/%h", i, out_valid, out_sel, out_data, exp_sel, exp_data);
      end
    end
    $display("test_round_robin done");
  endtask

  task automatic test_backpressure();
    // continues from round robin: out_valid=1, out_sel=10, ptr=0
    out_ready = 1'b0; in_valid = 3'b111;
    for (int i = 0; i < 3; i++) begin
      #1;
      asserts++;
      if (in_ready !== 3'b000) begin failures++; $display("FAIL bp_in_ready[%0d]: got %b want 000", i, in_ready); end
      asserts++;
      if (out_valid !== 1'b1 || out_sel !== 2'b10 || out_data !== 4'hC) begin
        failures++; $display("FAIL bp_hold[%0d]: got v=%b s=%b d=%h want 1/10/C", i, out_valid, out_sel, out_data);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    asserts++;
    if (in_ready !== 3'b001) begin failures++; $display("FAIL bp_release: got %b want 001", in_ready); end
    tick();
    asserts++;
    if (out_sel !== 2'b00 || out_data !== 4'hA) begin
      failures++; $display("FAIL bp_release_out: got s=%b d=%h want 00/A", out_sel, out_data);
    end
    $display("test_backpressure done");
  endtask

  task automatic test_reset_mid();
    // out_valid=1 (ch0 beat), ptr=1
    in_valid = 3'b111; out_ready = 1'b0; rst = 1'b1;
    #1;
    asserts++;
    if (in_ready !== 3'b000) begin failures++; $display("FAIL mid_rst_in_ready: got %b want 000", in_ready); end
    tick();
    rst = 1'b0; out_ready = 1'b1;
    #1;
    asserts++;
    if (out_valid !== 1'b0 || out_sel !== 2'b11) begin
      failures++; $display("FAIL mid_rst_out: got v=%b s=%b want 0/11", out_valid, out_sel);
    end
    asserts++;
    if (in_ready !== 3'b001) begin failures++; $display("FAIL mid_rst_first_grant: got %b want 001", in_ready); end
    tick();
    asserts++;
    if (out_sel !== 2'b00) begin failures++; $display("FAIL mid_rst_first_out: got %b want 00", out_sel); end
    in_valid = 3'b000;
    tick();
    $display("test_reset_mid done");
  endtask

`ifdef B1_MUX_GRANT_CNT_EN
  task automatic test_grant_cnt();
    logic [1:0] exp_cnt;
    do_reset();
    #1;
    asserts++;
    if (grant_cnt0 !== 2'd0 || grant_cnt1 !== 2'd0 || grant_cnt2 !== 2'd0) begin
      failures++; $display("FAIL cnt_reset: got %0d/%0d/%0d want 0/0/0", grant_cnt0, grant_cnt1, grant_cnt2);
    end
    in_valid = 3'b010; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_cnt = (i >= 2) ? 2'd3 : 2'(i + 1);
      tick();
      asserts++;
      if (grant_cnt1 !== exp_cnt || grant_cnt0 !== 2'd0 || grant_cnt2 !== 2'd0) begin
        failures++; $display("FAIL cnt1[%0d]: got %0d/%0d/%0d want 0/%0d/0", i, grant_cnt0, grant_cnt1, grant_cnt2, exp_cnt);
      end
    end
    in_valid = 3'b000;
    tick();
    $display("test_grant_cnt done");
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 3'b000; out_ready = 1'b0;
    in_data = {4'hC, 4'h1, 4'hA};
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
`ifdef B1_MUX_GRANT_CNT_EN
    test_grant_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
